// File: rtl/bcd_clock_counter_pkg.sv
// Shared BCD types, limits and digit arithmetic for the time-of-day counter.
package bcd_clock_counter_pkg;

   typedef logic [3:0] bcd_digit_t;
   typedef logic [7:0] bcd_byte_t;

   localparam int unsigned BCD_MAX_UNIT    = 32'd9;
   localparam int unsigned BCD_MAX_TENS_MS = 32'd5;

   function automatic logic bcd_valid(input bcd_byte_t v, input int unsigned tens_max);
      return ({28'd0, v[3:0]} <= BCD_MAX_UNIT) && ({28'd0, v[7:4]} <= tens_max);
   endfunction

   function automatic int unsigned bcd_to_bin(input bcd_byte_t v);
      return ({28'd0, v[7:4]} * 32'd10) + {28'd0, v[3:0]};
   endfunction

   function automatic bcd_byte_t bin_to_bcd(input int unsigned n);
      return {4'(n / 32'd10), 4'(n % 32'd10)};
   endfunction

   // Legal digits and a value strictly below the modulus
   function automatic logic bcd_check_mod(input bcd_byte_t v, input int unsigned modulus);
      return bcd_valid(v, (modulus - 32'd1) / 32'd10) && (bcd_to_bin(v) < modulus);
   endfunction

   function automatic bcd_byte_t bcd_inc_mod(input bcd_byte_t v, input bcd_byte_t last);
      bcd_byte_t r;
      if (v == last) begin
         r = 8'h00;
      end else if (v[3:0] == 4'd9) begin
         r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_clock_counter_mod_counter.sv
// One packed-BCD digit pair counting 00..MOD-1 with validated load and a
// registered wrap pulse aligned with the 00 value.
module bcd_mod_counter
   import bcd_clock_counter_pkg::*;
#(
   parameter int unsigned MOD = 60
) (
   input  logic      CP,
   input  logic      CR,
   input  logic      inc,
   input  logic      ld,
   input  bcd_byte_t d,
   output bcd_byte_t q,
   output logic      wrap
);

   localparam bcd_byte_t LAST = bin_to_bcd(MOD - 32'd1);

   bcd_byte_t q_d, q_q;
   logic      wrap_d, wrap_q;

   // Load beats increment; wrap is only raised by the increment that leaves LAST
   always_comb begin
      q_d    = q_q;
      wrap_d = 1'b0;
      if (ld) begin
         q_d = bcd_check_mod(d, MOD) ? d : 8'h00;
      end else if (inc) begin
         q_d    = bcd_inc_mod(q_q, LAST);
         wrap_d = (q_q == LAST);
      end else begin
         q_d = q_q;
      end
   end

   // State register
   always_ff @(posedge CP or negedge CR) begin
      if (!CR) begin
         q_q    <= 8'h00;
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
      end
   end

   assign q    = q_q;
   assign wrap = wrap_q;

endmodule

// File: rtl/bcd_clock_counter.sv
// Time-of-day counter (hh:mm:ss, packed BCD) driven by a 1 Hz tick.
// Optional alarm comparator is compiled in with BCD_CLOCK_ALARM_EN.
module bcd_clock_counter
   import bcd_clock_counter_pkg::*;
#(
   parameter int unsigned HOUR_MOD = 24
) (
   input  logic       CP,
   input  logic       CR,
   input  logic       TICK,
   input  logic       EN,
   input  logic       LD,
   input  logic [7:0] D_H,
   input  logic [7:0] D_M,
   input  logic [7:0] D_S,
`ifdef BCD_CLOCK_ALARM_EN
   input  logic       AL_LD,
   input  logic [7:0] AL_H,
   input  logic [7:0] AL_M,
   output logic       ALARM,
`endif
   output logic [7:0] Q_H,
   output logic [7:0] Q_M,
   output logic [7:0] Q_S,
   output logic       Co_S,
   output logic       Co_M,
   output logic       Co_D
);

   logic cnt_s, ld_s, sec_last_s, min_last_s, inc_m_s, inc_h_s;

   assign cnt_s      = TICK & EN;
   assign ld_s       = ~LD;
   assign sec_last_s = (Q_S == 8'h59);
   assign min_last_s = (Q_M == 8'h59);
   assign inc_m_s    = cnt_s & sec_last_s;
   assign inc_h_s    = inc_m_s & min_last_s;

   bcd_mod_counter #(.MOD(32'd60)) u_sec (
      .CP(CP), .CR(CR), .inc(cnt_s), .ld(ld_s), .d(D_S), .q(Q_S), .wrap(Co_S)
   );

   bcd_mod_counter #(.MOD(32'd60)) u_min (
      .CP(CP), .CR(CR), .inc(inc_m_s), .ld(ld_s), .d(D_M), .q(Q_M), .wrap(Co_M)
   );

   bcd_mod_counter #(.MOD(HOUR_MOD)) u_hour (
      .CP(CP), .CR(CR), .inc(inc_h_s), .ld(ld_s), .d(D_H), .q(Q_H), .wrap(Co_D)
   );

`ifdef BCD_CLOCK_ALARM_EN
   localparam bcd_byte_t H_LAST = bin_to_bcd(HOUR_MOD - 32'd1);

   logic [7:0] al_h_d, al_h_q, al_m_d, al_m_q;
   logic [7:0] nxt_h_s, nxt_m_s;
   logic       alarm_d, alarm_q, hit_s;

   // Look ahead to the time this edge will produce; a hit always lands on ss=00
   always_comb begin
      nxt_m_s = sec_last_s ? bcd_inc_mod(Q_M, 8'h59) : Q_M;
      nxt_h_s = (sec_last_s && min_last_s) ? bcd_inc_mod(Q_H, H_LAST) : Q_H;
      hit_s   = cnt_s & LD & sec_last_s & (nxt_h_s == al_h_q) & (nxt_m_s == al_m_q);
   end

   // Alarm load clears the flag and wins over a simultaneous hit
   always_comb begin
      al_h_d  = al_h_q;
      al_m_d  = al_m_q;
      alarm_d = alarm_q;
      if (!AL_LD) begin
         al_h_d  = bcd_check_mod(AL_H, HOUR_MOD) ? AL_H : 8'h00;
         al_m_d  = bcd_check_mod(AL_M, 32'd60) ? AL_M : 8'h00;
         alarm_d = 1'b0;
      end else if (hit_s) begin
         alarm_d = 1'b1;
      end else begin
         alarm_d = alarm_q;
      end
   end

   // Alarm registers
   always_ff @(posedge CP or negedge CR) begin
      if (!CR) begin
         al_h_q  <= 8'h00;
         al_m_q  <= 8'h00;
         alarm_q <= 1'b0;
      end else begin
         al_h_q  <= al_h_d;
         al_m_q  <= al_m_d;
         alarm_q <= alarm_d;
      end
   end

   assign ALARM = alarm_q;
`endif

endmodule

// File: tb/tb_bcd_clock_counter.sv
// Randomised and directed bench for bcd_clock_counter in 24- and 12-hour builds,
// checked against a seconds-of-day arithmetic model.
module tb_bcd_clock_counter;

   logic       CP, CR, TICK, EN, LD;
   logic [7:0] D_H, D_M, D_S;
   logic [7:0] q_h[2], q_m[2], q_s[2];
   logic       co_s[2], co_m[2], co_d[2];
`ifdef BCD_CLOCK_ALARM_EN
   logic       AL_LD;
   logic [7:0] AL_H, AL_M;
   logic       alarm[2];
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // model state: seconds since midnight per instance
   int unsigned mods[2];
   int unsigned t_m[2];
   bit          cs_m[2], cm_m[2], cd_m[2];
   int unsigned al_t[2];
   bit          alarm_m[2];

   bcd_clock_counter #(.HOUR_MOD(24)) u24 (
      .CP(CP), .CR(CR), .TICK(TICK), .EN(EN), .LD(LD),
      .D_H(D_H), .D_M(D_M), .D_S(D_S),
`ifdef BCD_CLOCK_ALARM_EN
      .AL_LD(AL_LD), .AL_H(AL_H), .AL_M(AL_M), .ALARM(alarm[0]),
`endif
      .Q_H(q_h[0]), .Q_M(q_m[0]), .Q_S(q_s[0]),
      .Co_S(co_s[0]), .Co_M(co_m[0]), .Co_D(co_d[0])
   );

   bcd_clock_counter #(.HOUR_MOD(12)) u12 (
      .CP(CP), .CR(CR), .TICK(TICK), .EN(EN), .LD(LD),
      .D_H(D_H), .D_M(D_M), .D_S(D_S),
`ifdef BCD_CLOCK_ALARM_EN
      .AL_LD(AL_LD), .AL_H(AL_H), .AL_M(AL_M), .ALARM(alarm[1]),
`endif
      .Q_H(q_h[1]), .Q_M(q_m[1]), .Q_S(q_s[1]),
      .Co_S(co_s[1]), .Co_M(co_m[1]), .Co_D(co_d[1])
   );

   initial begin
      CP = 1'b0;
      forever #5 CP = ~CP;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int unsigned n);
      return {4'(n / 10), 4'(n % 10)};
   endfunction

   function automatic int unsigned dec_val(input logic [7:0] v);
      return int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic bit field_ok(input logic [7:0] v, input int unsigned lim);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (dec_val(v) < lim);
   endfunction

   function automatic int unsigned load_secs(input logic [7:0] h, input logic [7:0] m,
                                             input logic [7:0] s, input int unsigned hmod);
      int unsigned hh, mm, ss;
      hh = field_ok(h, hmod) ? dec_val(h) : 0;
      mm = field_ok(m, 60) ? dec_val(m) : 0;
      ss = field_ok(s, 60) ? dec_val(s) : 0;
      return hh * 3600 + mm * 60 + ss;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         t_m[k] = 0; cs_m[k] = 0; cm_m[k] = 0; cd_m[k] = 0;
         al_t[k] = 0; alarm_m[k] = 0;
      end
   endtask

   // one rising edge with CR high
   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         bit counted;
         counted = 0;
         if (!LD) begin
            t_m[k] = load_secs(D_H, D_M, D_S, mods[k]);
            cs_m[k] = 0; cm_m[k] = 0; cd_m[k] = 0;
         end else if (TICK && EN) begin
            t_m[k] = (t_m[k] + 1) % (mods[k] * 3600);
            cs_m[k] = (t_m[k] % 60) == 0;
            cm_m[k] = (t_m[k] % 3600) == 0;
            cd_m[k] = (t_m[k] == 0);
            counted = 1;
         end else begin
            cs_m[k] = 0; cm_m[k] = 0; cd_m[k] = 0;
         end
`ifdef BCD_CLOCK_ALARM_EN
         if (!AL_LD) begin
            al_t[k] = load_secs(AL_H, AL_M, 8'h00, mods[k]);
            alarm_m[k] = 0;
         end else if (counted && t_m[k] == al_t[k]) begin
            alarm_m[k] = 1;
         end
`endif
      end
   endtask

   task automatic compare_all(input string tag);
      for (int k = 0; k < 2; k++) begin
         logic [31:0] exp, got;
         exp = {5'd0, to_bcd(t_m[k] / 3600), to_bcd((t_m[k] / 60) % 60), to_bcd(t_m[k] % 60),
                cs_m[k], cm_m[k], cd_m[k]};
         got = {5'd0, q_h[k], q_m[k], q_s[k], co_s[k], co_m[k], co_d[k]};
         check($sformatf("%s/h%0d", tag, mods[k]), got, exp);
`ifdef BCD_CLOCK_ALARM_EN
         check($sformatf("%s/h%0d/alarm", tag, mods[k]), {31'd0, alarm[k]}, {31'd0, alarm_m[k]});
`endif
      end
   endtask

   task automatic cycle(input string tag);
      @(posedge CP);
      model_edge();
      #1;
      compare_all(tag);
   endtask

   task automatic drive(input logic ld, input logic tick, input logic en,
                        input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      LD = ld; TICK = tick; EN = en; D_H = h; D_M = m; D_S = s;
   endtask

   initial begin
      mods[0] = 24;
      mods[1] = 12;
      model_reset();
      CR = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
`ifdef BCD_CLOCK_ALARM_EN
      AL_LD = 1'b1; AL_H = 8'h00; AL_M = 8'h00;
`endif
      repeat (2) @(posedge CP);
      #1;
      compare_all("reset");
      CR = 1'b1;

      // async clear mid-cycle from 12:34:56
      drive(1'b0, 1'b0, 1'b1, 8'h12, 8'h34, 8'h56);
      cycle("load_123456");
      drive(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
      #2;
      CR = 1'b0;
      #1;
      model_reset();
      compare_all("async_clear");
      #1;
      CR = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
      cycle("tick_on_release");

      // seconds wrap
      drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h58);
      cycle("load_58");
      drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
      cycle("sec_59");
      cycle("sec_wrap");
      drive(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
      cycle("sec_idle");

      // day rollover in both modes
      drive(1'b0, 1'b0, 1'b1, 8'h23, 8'h59, 8'h59);
      cycle("load_235959");
      drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
      cycle("roll_235959");
      drive(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
      cycle("roll_idle_a");
      drive(1'b0, 1'b0, 1'b1, 8'h11, 8'h59, 8'h59);
      cycle("load_115959");
      drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
      cycle("roll_115959");
      drive(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
      cycle("roll_idle_b");

      // load priority and per-field validation
      drive(1'b0, 1'b1, 1'b1, 8'h25, 8'h3A, 8'h07);
      cycle("load_invalid");
      drive(1'b0, 1'b1, 1'b1, 8'h1F, 8'h60, 8'hA0);
      cycle("load_invalid_b");

      // enable gating then consecutive ticks
      drive(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 5; i++) cycle("en_off");
      drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
      cycle("load_zero");
      drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++) cycle("b2b_tick");

`ifdef BCD_CLOCK_ALARM_EN
      AL_LD = 1'b0; AL_H = 8'h07; AL_M = 8'h30;
      drive(1'b0, 1'b0, 1'b1, 8'h07, 8'h29, 8'h59);
      cycle("alarm_setup");
      AL_LD = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
      cycle("alarm_hit");
      for (int i = 0; i < 10; i++) cycle("alarm_hold");
      AL_LD = 1'b0;
      drive(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
      cycle("alarm_clear");
      AL_LD = 1'b1;
`endif

      // randomised traffic biased toward wrap boundaries
      for (int i = 0; i < 600; i++) begin
         LD   = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
         TICK = ($urandom_range(0, 3) != 0);
         EN   = ($urandom_range(0, 5) != 0);
         if ($urandom_range(0, 2) == 0) begin
            D_H = 8'($urandom);
            D_M = 8'($urandom);
            D_S = 8'($urandom);
         end else begin
            case ($urandom_range(0, 2))
               0:       D_H = 8'h23;
               1:       D_H = 8'h11;
               default: D_H = to_bcd($urandom_range(0, 23));
            endcase
            D_M = ($urandom_range(0, 1) != 0) ? 8'h59 : to_bcd($urandom_range(0, 59));
            D_S = to_bcd($urandom_range(50, 59));
         end
`ifdef BCD_CLOCK_ALARM_EN
         AL_LD = ($urandom_range(0, 40) == 0) ? 1'b0 : 1'b1;
         AL_H  = to_bcd($urandom_range(0, 23));
         AL_M  = ($urandom_range(0, 1) != 0) ? 8'h00 : to_bcd($urandom_range(0, 59));
`endif
         cycle("random");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_clock_counter.md
Name: bcd_clock_counter

Overview:
- Time-of-day counter sitting directly downstream of the my74LS161 prescaler chain.
- Consumes the chain's one-cycle terminal-carry pulse as a 1 Hz tick and counts seconds, minutes and hours in packed BCD.
- Outputs feed the display scan stage.
- Supports a synchronous parallel load for time setting, plus cascade carries for day-rollover logic.

Parameters:
- HOUR_MOD, 24: hour modulus, legal values 12 or 24. Hours count 00..HOUR_MOD-1.

Ports:
- CP  input  1  clock, rising-edge active.
- CR  input  1  asynchronous active-low clear.
- TICK  input  1  count pulse from the prescaler Co; high for exactly one CP cycle per second.
- EN  input  1  count enable; TICK is ignored while EN=0.
- LD  input  1  synchronous active-low parallel load.
- D_H  input  8  BCD hours to load, {tens, units}.
- D_M  input  8  BCD minutes to load.
- D_S  input  8  BCD seconds to load.
- Q_H  output  8  BCD hours, registered.
- Q_M  output  8  BCD minutes, registered.
- Q_S  output  8  BCD seconds, registered.
- Co_S  output  1  seconds wrap pulse, registered.
- Co_M  output  1  minutes wrap pulse, registered.
- Co_D  output  1  day wrap pulse, registered.

Behaviour:
- Clock and reset: one clock CP; reset CR is asynchronous, active-low. While CR=0, all outputs are 0 (Q_H=Q_M=Q_S=8'h00, Co_*=0) regardless of CP.
- Priority per rising CP edge (CR=1): LD=0 first, then TICK&EN, otherwise hold.
- Load (LD=0):
  - Each field is checked independently for validity. Invalid means: any nibble >9, seconds or minutes tens >5, or hours >= HOUR_MOD.
  - A valid field is loaded as given; an invalid field loads 8'h00.
  - All Co_* are 0 in the cycle following a load.
  - Load takes effect on the same edge; LD=0 with TICK=1 means the tick is dropped.
- Count (TICK&EN, LD=1):
  - Seconds increment in BCD: units 9→0 carries to tens; 59→00 wraps.
  - A seconds wrap increments minutes the same way; a minutes wrap increments hours.
  - Hours wrap from HOUR_MOD-1 to 00. 24-hour mode: 23→00. 12-hour mode: 11→00.
  - The counter never produces a non-BCD value.
- Carries (registered, one-cycle pulses, asserted on the edge that performs the wrap):
  - Co_S=1 iff seconds went 59→00.
  - Co_M=1 iff Co_S and minutes went 59→00.
  - Co_D=1 iff Co_M and hours wrapped to 00.
  - All carries return to 0 on the next edge unless another wrap occurs.
- Latency: Q changes on the same edge that samples TICK. There is no pipeline; Co_* are aligned with the new Q value.
- Hold: TICK=0 or EN=0 keeps Q and clears Co_*.
- Reset mid-count: CR falling forces zeros immediately, without waiting for an edge. On release the first edge behaves normally; a TICK coincident with the release edge counts.
- Back-to-back TICK on consecutive cycles counts each one; the block has no rate assumption.

Optional Feature:
- Macro: BCD_CLOCK_ALARM_EN.
- With the macro defined, these ports are added:
  - AL_LD (input, 1): active-low alarm load.
  - AL_H, AL_M (input, 8 each): alarm time in BCD.
  - ALARM (output, 1).
- Alarm registers reset to 8'h00; invalid alarm values load as 00.
- ALARM is set on the edge where Q_H:Q_M:Q_S becomes AL_H:AL_M:00 through counting (not through load).
- ALARM stays set until AL_LD=0 or CR=0.
- Without the macro, the ports, registers and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package contents:
  - BCD digit and byte typedefs.
  - Constants BCD_MAX_UNIT=9, BCD_MAX_TENS_MS=5.
  - A BCD-validity function, parameterised on tens limit.
- Sub-module bcd_mod_counter (parameter MOD; ports CP, CR, inc, ld, d, q, wrap) is instantiated three times. Seconds and minutes use MOD=60; hours use MOD=HOUR_MOD.

Test Plan:
- Reset: CR=0 asynchronously mid-cycle with Q=12:34:56 → Q=00:00:00 and Co_*=0 immediately, before the next CP edge.
- Seconds wrap: load 00:00:58, then 2 TICKs with EN=1 → Q_S=59, then 00 with Co_S=1 and Q_M=01; Co_S=0 on the next idle edge.
- Day rollover (HOUR_MOD=24): load 23:59:59, one TICK → 00:00:00 with Co_S=Co_M=Co_D=1 for one cycle. Repeat with HOUR_MOD=12 from 11:59:59 → same result.
- Load priority and validation: LD=0 with TICK=1, D_H=8'h25, D_M=8'h3A, D_S=8'h07 → Q=00:00:07 and Co_*=0; tick not counted.
- Enable gating: EN=0 with 5 TICKs → Q unchanged. EN=1 with TICK held high 3 consecutive cycles from 00:00:00 → 00:00:03.
- Alarm (BCD_CLOCK_ALARM_EN): AL_H=8'h07, AL_M=8'h30, load 07:29:59, one TICK → ALARM=1 and stays 1 after 10 more TICKs; AL_LD=0 → ALARM=0.
